// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stall/flush/redirect controller for the 6-stage pipeline
//                (PC, IF, ID, EX, MEM, WB). Merges per-stage stall requests
//                into a shared hold vector, arbitrates exception/ertn/branch
//                redirects, holds a redirect while the ICache is busy, and
//                counts front-end stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause_if_i,
  input  logic             pause_id_i,
  input  logic             pause_ex_i,
  input  logic             pause_mem_i,
  input  logic             icache_busy_i,
  input  logic             branch_flush_i,
  input  logic [31:0]      branch_target_i,
  input  logic             excp_i,
  input  logic [31:0]      excp_entry_i,
  input  logic             ertn_i,
  input  logic [31:0]      era_i,
  output logic [5:0]       pause_o,
  output logic             branch_flush_o,
  output logic             excp_flush_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Redirect FSM: IDLE issues redirects directly, PEND waits for the ICache.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [5:0]         w_req_full;
  logic [5:0]         w_req_exmem;
  logic               w_excp_ev;
  logic               w_fresh_br;
  logic               w_br_flush;
  logic               w_new_ev;
  logic [31:0]        w_target;
  logic [5:0]         w_pause;
  logic               w_rv;
  logic [31:0]        w_rpc;

  // Stall merge, flush arbitration, target selection and redirect issue.
  always_comb begin
    // A request from stage k holds stages 0..k; WB is never held.
    w_req_exmem    = 6'b000000;
    w_req_exmem[4] = pause_mem_i;
    w_req_exmem[3] = pause_mem_i | pause_ex_i;
    w_req_exmem[2] = pause_mem_i | pause_ex_i;
    w_req_exmem[1] = pause_mem_i | pause_ex_i;
    w_req_exmem[0] = pause_mem_i | pause_ex_i;

    w_req_full     = w_req_exmem;
    w_req_full[2]  = w_req_exmem[2] | pause_id_i;
    w_req_full[1]  = w_req_exmem[1] | pause_id_i | pause_if_i;
    w_req_full[0]  = w_req_exmem[0] | pause_id_i | pause_if_i;

    // Exceptions/ertn commit from MEM, so they wait while MEM is stalled.
    w_excp_ev  = (excp_i | ertn_i) & ~pause_mem_i;

    // pause[3] only depends on ex/mem requests, so there is no loop through
    // the "branch flush ignores if/id stalls" rule. Gating on EX being held
    // makes a branch held under a MEM stall fire exactly once.
    w_fresh_br = branch_flush_i & ~w_req_full[3] & ~w_excp_ev;

    // While a redirect is pending, keep killing wrong-path fetches.
    w_br_flush = ~w_excp_ev & (w_fresh_br | (state_q == ST_PEND));
    w_new_ev   = w_excp_ev | w_fresh_br;

    if (excp_i) begin
      w_target = excp_entry_i;
    end else if (ertn_i) begin
      w_target = era_i;
    end else begin
      w_target = branch_target_i;
    end

    if (w_excp_ev) begin
      w_pause = 6'b000000;
    end else if (w_br_flush) begin
      w_pause = w_req_exmem;
    end else begin
      w_pause = w_req_full;
    end

    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    w_rv      = 1'b0;
    w_rpc     = 32'h0;

    if (w_new_ev) begin
      // A new event always supersedes whatever is pending.
      if (icache_busy_i) begin
        pend_pc_d = w_target;
        state_d   = ST_PEND;
      end else begin
        w_rv    = 1'b1;
        w_rpc   = w_target;
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_PEND) begin
      if (!icache_busy_i) begin
        w_rv    = 1'b1;
        w_rpc   = pend_pc_q;
        state_d = ST_IDLE;
      end
    end

    // Front-end stall cycle counter, saturating at all-ones.
    if (w_pause[0] && !(&cnt_q)) begin
      cnt_d = cnt_q + C_CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Combinational outputs are held at zero throughout reset.
  always_comb begin
    pause_o          = rst ? 6'b000000 : w_pause;
    branch_flush_o   = ~rst & w_br_flush;
    excp_flush_o     = ~rst & w_excp_ev;
    redirect_valid_o = ~rst & w_rv;
    redirect_pc_o    = rst ? 32'h0 : w_rpc;
  end

  // Redirect FSM state and pending target register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;

  // Exception and ertn are mutually exclusive commits from MEM.
  a_excp_ertn_excl : assert property (@(posedge clk) disable iff (rst) !(excp_i && ertn_i));

endmodule
`default_nettype wire
